reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined CPU.
- Generalises the 2-read/1-write file to NUM_RD read ports and NUM_WR write ports.
- Keeps write-to-read bypass and a hardwired zero register.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback) for hazard detection in decode.
- Sits between ID (reads, issue) and WB (writes).

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_scoreboard.sv | 65 ++++++
 rtl/reg_file_mp.sv | 90 +++++++++
 tb/tb_reg_file_mp.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port integer register file.
// Default widths, register count and the hardwired zero-register index.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, set wins.
// Optional raw busy vector output when REG_FILE_MP_DEBUG_EN is defined.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
`ifdef REG_FILE_MP_DEBUG_EN
    ,
    output logic [2**ADDR_W-1:0]     busy_vec
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
                wr_hit[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
        end
    end

    // Issue beats writeback on the same register: old producer retires, new one takes over.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (iss_en && iss_addr == ADDR_W'(r))
                    busy[r] <= 1'b1;
                else if (wr_hit[r])
                    busy[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        a       = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a          = rd_addr[k*ADDR_W +: ADDR_W];
            rd_busy[k] = (a != ADDR_W'(ZERO_REG)) && busy[a] && !wr_hit[a];
        end
    end

`ifdef REG_FILE_MP_DEBUG_EN
    assign busy_vec = busy;
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass, zero register and busy scoreboard.
// Define REG_FILE_MP_DEBUG_EN to add the dbg_addr/dbg_data/dbg_busy inspection ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
`ifdef REG_FILE_MP_DEBUG_EN
    ,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [2**ADDR_W-1:0]     dbg_busy
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Later ports overwrite earlier ones, so the highest enabled index wins on collisions.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < DEPTH; r++)
                regs[r] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
                    regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

    // Bypass is suppressed during reset so outputs read zero immediately.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] val;
        a       = '0;
        val     = '0;
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a   = rd_addr[k*ADDR_W +: ADDR_W];
            val = '0;
            if (rstn && a != ADDR_W'(ZERO_REG)) begin
                val = regs[a];
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == a)
                        val = wr_data[p*DATA_W +: DATA_W];
                end
            end
            rd_data[k*DATA_W +: DATA_W] = val;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
`ifdef REG_FILE_MP_DEBUG_EN
        ,
        .busy_vec (dbg_busy)
`endif
    );

`ifdef REG_FILE_MP_DEBUG_EN
    assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized self-checking bench for reg_file_mp against an array/bitmask reference model.
// Directed cases cover reset, bypass, write priority, zero register and scoreboard.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 2 ** AW;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
`ifdef REG_FILE_MP_DEBUG_EN
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;
    logic [DEPTH-1:0]  dbg_busy;
`endif

    // Stimulus as unpacked fields; packed onto the DUT buses continuously.
    logic [AW-1:0] ra [NR];
    logic          we [NW];
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];

    // Reference model state.
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] mbusy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = ra[k];
        for (int p = 0; p < NW; p++) begin
            wr_en[p]             = we[p];
            wr_addr[p*AW +: AW]  = wa[p];
            wr_data[p*DW +: DW]  = wd[p];
        end
    end

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
`ifdef REG_FILE_MP_DEBUG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_busy (dbg_busy)
`endif
    );

    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Same-cycle write to a (highest enabled port wins), if any.
    function automatic bit write_to(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bit hit = 0;
        d = '0;
        if (a == 0) return 0;
        for (int p = 0; p < NW; p++)
            if (we[p] && wa[p] == a) begin hit = 1; d = wd[p]; end
        return hit;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        if (!rstn || a == 0) return '0;
        if (write_to(a, d)) return d;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        if (!rstn || a == 0) return 1'b0;
        return mbusy[a] && !write_to(a, d);
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NR; k++) begin
            check_output($sformatf("%s rd_data%0d", tag, k), rd_data[k*DW +: DW], exp_data(ra[k]));
            check_output($sformatf("%s rd_busy%0d", tag, k), DW'(rd_busy[k]), DW'(exp_busy(ra[k])));
        end
`ifdef REG_FILE_MP_DEBUG_EN
        check_output($sformatf("%s dbg_data", tag), dbg_data, mem[dbg_addr]);
        check_output($sformatf("%s dbg_busy", tag), DW'(dbg_busy), DW'(mbusy));
`endif
    endtask

    task automatic reset_model();
        for (int r = 0; r < DEPTH; r++) mem[r] = '0;
        mbusy = '0;
    endtask

    // Edge behaviour: writes store in port order, then issue/clear for the scoreboard.
    task automatic update_model();
        logic [DEPTH-1:0] nb;
        logic [DW-1:0] d;
        if (!rstn) begin
            reset_model();
            return;
        end
        nb = mbusy;
        for (int r = 1; r < DEPTH; r++) begin
            if (iss_en && iss_addr == AW'(r)) nb[r] = 1'b1;
            else if (write_to(AW'(r), d)) nb[r] = 1'b0;
        end
        for (int p = 0; p < NW; p++)
            if (we[p] && wa[p] != 0) mem[wa[p]] = wd[p];
        mbusy = nb;
    endtask

    task automatic apply_stimulus(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                  input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                  input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                  input logic ie, input logic [AW-1:0] ia);
        ra[0] = r0; ra[1] = r1;
        we[0] = e0; wa[0] = a0; wd[0] = d0;
        we[1] = e1; wa[1] = a1; wd[1] = d1;
        iss_en = ie; iss_addr = ia;
    endtask

    task automatic cycle(input string tag);
        #1 check_all(tag);
        update_model();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        reset_model();
`ifdef REG_FILE_MP_DEBUG_EN
        dbg_addr = '0;
`endif
        apply_stimulus(5'd5, 5'd3, 1, 5'd5, 32'h1111, 0, 5'd0, 0, 1, 5'd5);
        @(negedge clk);
        cycle("reset");
        rstn = 1'b1;

        // Mid-cycle reset discards the pending write and zeroes outputs at once.
        apply_stimulus(5'd5, 5'd5, 1, 5'd5, 32'hDEAD, 0, 5'd0, 0, 1, 5'd5);
        cycle("wr x5");
        apply_stimulus(5'd5, 5'd1, 1, 5'd5, 32'hBEEF, 0, 5'd0, 0, 0, 5'd0);
        #1 check_all("pre-reset bypass");
        #2 rstn = 1'b0;
        reset_model();
        cycle("mid reset");
        rstn = 1'b1;
        apply_stimulus(5'd5, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("after reset");

        apply_stimulus(5'd3, 5'd3, 1, 5'd3, 32'h1234, 0, 5'd0, 0, 0, 5'd0);
        cycle("bypass x3");
        apply_stimulus(5'd3, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("stored x3");

        apply_stimulus(5'd7, 5'd3, 1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 5'd0);
        cycle("prio bypass x7");
        apply_stimulus(5'd7, 5'd7, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("prio stored x7");

        apply_stimulus(5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0);
        cycle("zero wr");
        apply_stimulus(5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("zero rd");

        apply_stimulus(5'd9, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9);
        cycle("iss x9");
        apply_stimulus(5'd9, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("busy x9");
        apply_stimulus(5'd9, 5'd9, 0, 5'd0, 0, 1, 5'd9, 32'h99, 0, 5'd0);
        cycle("wb x9");
        apply_stimulus(5'd9, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("clear x9");
        apply_stimulus(5'd9, 5'd9, 1, 5'd9, 32'h9A, 0, 5'd0, 0, 1, 5'd9);
        cycle("iss+wb x9");
        apply_stimulus(5'd9, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("still busy x9");

`ifdef REG_FILE_MP_DEBUG_EN
        dbg_addr = 5'd4;
`endif
        apply_stimulus(5'd4, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd4);
        cycle("iss x4");
        apply_stimulus(5'd4, 5'd4, 1, 5'd4, 32'hA5A5, 0, 5'd0, 0, 0, 5'd0);
        cycle("dbg wr x4");
        apply_stimulus(5'd4, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
        cycle("dbg after x4");

        // Narrow address range forces frequent collisions between ports.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)),
                           1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                           1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                           1'($urandom), AW'($urandom_range(0, 7)));
`ifdef REG_FILE_MP_DEBUG_EN
            dbg_addr = AW'($urandom_range(0, 7));
`endif
            cycle($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
